// File: rtl/adc_scan.sv
// Scanning controller for a 12-bit SPI-style ADC: runs CONVST/shift frames,
// sends the channel config word, and averages returned samples per channel.
module adc_scan #(
    parameter int NUM_CHAN    = 8,
    parameter int AVG_LOG2    = 2,
    parameter int CLK_DIV     = 4,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        mode,
    input  logic [2:0]  chan_sel,
    input  logic [2:0]  rd_chan,
    output logic [11:0] rd_data,
    output logic        new_sample,
    output logic [2:0]  sample_chan,
    output logic        ADC_CONVST,
    output logic        ADC_SCK,
    output logic        ADC_SDI,
    input  logic        ADC_SDO
);

    localparam int CNT_MAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int AW      = 12 + AVG_LOG2;
    localparam int NW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [2:0]    CHAN_LAST = 3'(NUM_CHAN - 1);
    localparam logic [NW-1:0] NUM_FULL  = NW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hi_q, hi_d;
    logic [3:0]      bit_q, bit_d;
    logic [2:0]      chan_q, chan_d;
    logic [2:0]      dchan_q, dchan_d;
    logic            prime_q, prime_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [11:0]     sr_q, sr_d;
    logic            done_q, done_d;
    logic            new_sample_q, new_sample_d;
    logic [2:0]      sample_chan_q, sample_chan_d;
    logic [AW-1:0]   acc_q [8];
    logic [AW-1:0]   acc_d [8];
    logic [NW-1:0]   num_q [8];
    logic [NW-1:0]   num_d [8];
    logic [11:0]     res_q [8];
    logic [11:0]     res_d [8];

    logic            frame_start;
    logic [AW-1:0]   sum;
    logic [5:0]      cfg;
    logic [5:0]      cfg_sh;

    function automatic logic [11:0] avg_trunc(input logic [AW-1:0] s);
        avg_trunc = 12'(s >> AVG_LOG2);
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        bit_d         = bit_q;
        chan_d        = chan_q;
        dchan_d       = dchan_q;
        prime_d       = prime_q;
        ptr_d         = ptr_q;
        sr_d          = sr_q;
        done_d        = 1'b0;
        new_sample_d  = 1'b0;
        sample_chan_d = sample_chan_q;
        acc_d         = acc_q;
        num_d         = num_q;
        res_d         = res_q;
        frame_start   = 1'b0;
        sum           = '0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d     = CONV;
                    cnt_d       = '0;
                    frame_start = 1'b1;
                end
            end
            CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hi_d    = 1'b0;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (bit_q == 4'd12) begin
                    // single gap clock closes the frame
                    if (enable) begin
                        state_d     = CONV;
                        cnt_d       = '0;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (hi_q) begin
                        hi_d  = 1'b0;
                        bit_d = bit_q + 4'd1;
                    end else begin
                        hi_d = 1'b1;
                        sr_d = {sr_q[10:0], ADC_SDO};
                        if (bit_q == 4'd11) begin
                            done_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // data read in the coming frame belongs to the channel configured in this one
        if (frame_start) begin
            dchan_d = chan_q;
            prime_d = (state_q == IDLE);
            if (mode) begin
                chan_d = ptr_q;
                ptr_d  = (ptr_q == CHAN_LAST) ? 3'd0 : ptr_q + 3'd1;
            end else begin
                chan_d = chan_sel;
            end
        end

        if (done_q && !prime_q && (int'(dchan_q) < NUM_CHAN)) begin
            sum = acc_q[dchan_q] + AW'(sr_q);
            if (num_q[dchan_q] == NUM_FULL) begin
                res_d[dchan_q] = avg_trunc(sum);
                acc_d[dchan_q] = '0;
                num_d[dchan_q] = '0;
                new_sample_d   = 1'b1;
                sample_chan_d  = dchan_q;
            end else begin
                acc_d[dchan_q] = sum;
                num_d[dchan_q] = num_q[dchan_q] + NW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= 1'b0;
            bit_q         <= 4'd0;
            chan_q        <= 3'd0;
            dchan_q       <= 3'd0;
            prime_q       <= 1'b1;
            ptr_q         <= 3'd0;
            sr_q          <= '0;
            done_q        <= 1'b0;
            new_sample_q  <= 1'b0;
            sample_chan_q <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                acc_q[i] <= '0;
                num_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            bit_q         <= bit_d;
            chan_q        <= chan_d;
            dchan_q       <= dchan_d;
            prime_q       <= prime_d;
            ptr_q         <= ptr_d;
            sr_q          <= sr_d;
            done_q        <= done_d;
            new_sample_q  <= new_sample_d;
            sample_chan_q <= sample_chan_d;
            acc_q         <= acc_d;
            num_q         <= num_d;
            res_q         <= res_d;
        end
    end

    // config word {1, c0, c2, c1, 1, 0}, MSB on the first SCK period
    assign cfg    = {1'b1, chan_q[0], chan_q[2], chan_q[1], 1'b1, 1'b0};
    assign cfg_sh = cfg << bit_q[2:0];

    assign ADC_CONVST  = (state_q == CONV);
    assign ADC_SCK     = (state_q == SHIFT) && hi_q;
    assign ADC_SDI     = (state_q == SHIFT) && (bit_q < 4'd6) && cfg_sh[5];
    assign rd_data     = res_q[rd_chan];
    assign new_sample  = new_sample_q;
    assign sample_chan = sample_chan_q;

endmodule

// File: tb/tb_adc_scan.sv
// Directed bench for adc_scan: two instances (4-chan no averaging, 8-chan 4x
// averaging), each driven by a small ADC model that decodes the config word.
module tb_adc_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // instance A: NUM_CHAN=4, AVG_LOG2=0
    logic        rst_a_n, en_a, mode_a;
    logic [2:0]  csel_a, rdc_a, sc_a;
    logic [11:0] rd_a;
    logic        ns_a, cv_a, sck_a, sdi_a, sdo_a;

    adc_scan #(.NUM_CHAN(4), .AVG_LOG2(0), .CLK_DIV(4), .CONV_CYCLES(80)) u_a (
        .clk(clk), .reset_n(rst_a_n), .enable(en_a), .mode(mode_a),
        .chan_sel(csel_a), .rd_chan(rdc_a), .rd_data(rd_a),
        .new_sample(ns_a), .sample_chan(sc_a),
        .ADC_CONVST(cv_a), .ADC_SCK(sck_a), .ADC_SDI(sdi_a), .ADC_SDO(sdo_a)
    );

    // instance B: NUM_CHAN=8, AVG_LOG2=2
    logic        rst_b_n, en_b, mode_b;
    logic [2:0]  csel_b, rdc_b, sc_b;
    logic [11:0] rd_b;
    logic        ns_b, cv_b, sck_b, sdi_b, sdo_b;

    adc_scan #(.NUM_CHAN(8), .AVG_LOG2(2), .CLK_DIV(4), .CONV_CYCLES(80)) u_b (
        .clk(clk), .reset_n(rst_b_n), .enable(en_b), .mode(mode_b),
        .chan_sel(csel_b), .rd_chan(rdc_b), .rd_data(rd_b),
        .new_sample(ns_b), .sample_chan(sc_b),
        .ADC_CONVST(cv_b), .ADC_SCK(sck_b), .ADC_SDI(sdi_b), .ADC_SDO(sdo_b)
    );

    // ADC model A: returns 0xABC, or 0x100*ch of the channel configured last frame
    bit          a_pat = 1'b0;
    int          a_frames = 0, a_rises = 0, a_rise0 = 0, a_falls = 0, a_fall0 = 0;
    int          a_prev_rise = 0, a_period = 0, a_bi;
    logic [5:0]  a_cfg_sh = '0, a_cfg = '0;
    logic [11:0] a_word = '0;

    always @(posedge cv_a) begin
        a_cfg       <= a_cfg_sh;
        a_word      <= a_pat ? {1'b0, a_cfg_sh[3], a_cfg_sh[2], a_cfg_sh[4], 8'h00} : 12'hABC;
        a_fall0     <= a_falls;
        a_rise0     <= a_rises;
        a_frames    <= a_frames + 1;
        a_period    <= cyc - a_prev_rise;
        a_prev_rise <= cyc;
    end

    always @(posedge sck_a) begin
        a_rises <= a_rises + 1;
        if (a_rises - a_rise0 < 6) a_cfg_sh <= {a_cfg_sh[4:0], sdi_a};
    end

    always @(negedge sck_a) a_falls <= a_falls + 1;

    assign a_bi  = a_falls - a_fall0;
    assign sdo_a = (a_bi >= 0 && a_bi < 12) ? a_word[4'(11 - a_bi)] : 1'b0;

    // ADC model B: one table entry per frame
    logic [11:0] b_tab [10] = '{12'h555, 12'h000, 12'h001, 12'h002, 12'h003,
                                12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h555};
    int          b_frames = 0, b_falls = 0, b_fall0 = 0, b_bi;
    logic [11:0] b_word = '0;

    always @(posedge cv_b) begin
        b_word   <= (b_frames < 10) ? b_tab[b_frames] : 12'h000;
        b_fall0  <= b_falls;
        b_frames <= b_frames + 1;
    end

    always @(negedge sck_b) b_falls <= b_falls + 1;

    assign b_bi  = b_falls - b_fall0;
    assign sdo_b = (b_bi >= 0 && b_bi < 12) ? b_word[4'(11 - b_bi)] : 1'b0;

    // output monitors
    logic [2:0] a_seq [16];
    int   a_ns_cnt = 0, a_ns_frame = 0, a_run = 0, a_hi_n = 0, a_hi_bad = 0, a_lo_bad = 0;
    logic a_sck_prev = 1'b0, a_first = 1'b1;
    int   b_ns_cnt = 0;
    logic [2:0] b_last_chan = 3'd7;

    always @(negedge clk) begin
        if (ns_a) begin
            if (a_ns_cnt < 16) a_seq[a_ns_cnt] <= sc_a;
            a_ns_cnt   <= a_ns_cnt + 1;
            a_ns_frame <= a_frames;
        end
        a_sck_prev <= sck_a;
        if (sck_a == a_sck_prev) begin
            a_run <= a_run + 1;
        end else begin
            a_run <= 1;
            if (a_sck_prev) begin
                a_hi_n <= a_hi_n + 1;
                if (a_run != 4) a_hi_bad <= a_hi_bad + 1;
            end else if (!a_first && a_run != 4) begin
                a_lo_bad <= a_lo_bad + 1;
            end
        end
        if (cv_a) a_first <= 1'b1;
        else if (sck_a && !a_sck_prev) a_first <= 1'b0;
        if (ns_b) begin
            b_ns_cnt    <= b_ns_cnt + 1;
            b_last_chan <= sc_b;
        end
    end

    task automatic wait_frames(input bit b, input int n);
        for (int i = 0; i < 4000; i++) begin
            if ((b ? b_frames : a_frames) >= n) return;
            @(negedge clk);
        end
        chk(b ? "b_frame_timeout" : "a_frame_timeout", b ? b_frames : a_frames, n);
    endtask

    task automatic wait_sck_a(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sck_a) return;
        end
        chk(tag, sck_a, 1);
    endtask

    int saved;

    initial begin
        rst_a_n = 1'b0; en_a = 1'b0; mode_a = 1'b0; csel_a = 3'd0; rdc_a = 3'd0;
        rst_b_n = 1'b0; en_b = 1'b0; mode_b = 1'b0; csel_b = 3'd0; rdc_b = 3'd0;
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_convst", cv_a, 0);
        chk("rst_sck", sck_a, 0);
        chk("rst_sdi", sdi_a, 0);
        chk("rst_new_sample", ns_a, 0);
        chk("rst_sample_chan", sc_a, 0);
        for (int r = 0; r < 4; r++) begin
            rdc_a = 3'(r); #1;
            chk($sformatf("rst_rd_data_%0d", r), rd_a, 0);
        end

        // single channel 3, constant 0xABC
        mode_a = 1'b0; csel_a = 3'd3; en_a = 1'b1;
        wait_frames(0, 2);
        chk("cfg_word_ch3", a_cfg, 6'b110110);
        chk("prime_no_ns", a_ns_cnt, 0);
        wait_frames(0, 3);
        chk("ns_cnt_f2", a_ns_cnt, 1);
        chk("ns_chan_f2", a_seq[0], 3);
        chk("ns_in_frame2", a_ns_frame, 2);
        chk("convst_period", a_period, 177);
        rdc_a = 3'd3; #1;
        chk("rd_ch3_abc", rd_a, 12'hABC);

        // drop enable during SHIFT of frame 3
        wait_sck_a("sck_f3_timeout");
        en_a = 1'b0; a_pat = 1'b1; mode_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_ns_cnt == 2) break;
        end
        chk("ns_after_disable", a_ns_cnt, 2);
        chk("ns_chan_f3", a_seq[1], 3);
        repeat (200) @(negedge clk);
        chk("idle_convst", cv_a, 0);
        chk("idle_sck", sck_a, 0);
        chk("idle_no_frame", a_frames, 3);
        chk("sck_hi_phases", a_hi_n, 36);
        chk("sck_hi_len_bad", a_hi_bad, 0);
        chk("sck_lo_len_bad", a_lo_bad, 0);

        // restart in scan mode: first frame primes
        en_a = 1'b1;
        wait_frames(0, 5);
        chk("prime_after_idle", a_ns_cnt, 2);
        wait_frames(0, 10);
        chk("scan_ns_cnt", a_ns_cnt, 7);
        for (int k = 0; k < 5; k++)
            chk($sformatf("scan_seq_%0d", k), a_seq[2 + k], k % 4);
        for (int c = 0; c < 4; c++) begin
            rdc_a = 3'(c); #1;
            chk($sformatf("scan_rd_%0d", c), rd_a, c * 256);
        end

        // reset in the middle of SHIFT
        wait_sck_a("sck_rst_timeout");
        #2 rst_a_n = 1'b0; en_a = 1'b0;
        #1;
        chk("midrst_convst", cv_a, 0);
        chk("midrst_sck", sck_a, 0);
        chk("midrst_sdi", sdi_a, 0);
        chk("midrst_new_sample", ns_a, 0);
        chk("midrst_sample_chan", sc_a, 0);
        for (int r = 0; r < 8; r++) begin
            rdc_a = 3'(r); #1;
            chk($sformatf("midrst_rd_%0d", r), rd_a, 0);
        end
        @(negedge clk);
        rst_a_n = 1'b1;
        saved = a_rises;
        repeat (300) @(negedge clk);
        chk("no_sck_after_rst", a_rises, saved);
        chk("no_convst_after_rst", cv_a, 0);

        // 4x averaging on channel 0
        mode_b = 1'b0; csel_b = 3'd0; rdc_b = 3'd0; en_b = 1'b1;
        wait_frames(1, 5);
        chk("avg_partial_ns", b_ns_cnt, 0);
        chk("avg_partial_rd", rd_b, 0);
        wait_frames(1, 6);
        chk("avg1_ns", b_ns_cnt, 1);
        chk("avg1_chan", b_last_chan, 0);
        chk("avg1_rd", rd_b, 12'h001);
        wait_frames(1, 10);
        chk("avg2_ns", b_ns_cnt, 2);
        chk("avg2_rd_nowrap", rd_b, 12'hFFF);
        en_b = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
